// File: rtl/control_reg_driver.sv
// CPU-writable control register: level-mode bits latch write data, pulse-mode bits fire a
// shared PulseWidth-clock pulse. Define CTRLREG_READBACK_EN to enable acked reads of control_bus.
module control_reg_driver #(
    parameter int         NumOutputs = 8,
    parameter logic [7:0] PulseMask  = 8'h00,
    parameter int         PulseWidth = 1,
    parameter logic [7:0] InitValue  = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bus_wr,
    input  logic       bus_rd,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_ack,
    output logic [7:0] control_bus,
    output logic       control_0,
    output logic       control_1,
    output logic       control_2,
    output logic       control_3,
    output logic       control_4,
    output logic       control_5,
    output logic       control_6,
    output logic       control_7
);
    localparam logic [7:0] AM  = 8'((9'd1 << NumOutputs) - 9'd1);
    localparam logic [7:0] PM  = PulseMask & AM;
    localparam logic [7:0] LM  = ~PulseMask & AM;
    localparam logic [4:0] PW5 = 5'(PulseWidth);

    typedef enum logic {IDLE, PULSE} state_t;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] pset_q, pset_d;
    logic [7:0] level_q, level_d;
    logic       ack_q;
    logic       rd_acc;
    logic [7:0] new_pulse;
    logic       trig;

    assign new_pulse = bus_wdata & PM;
    assign trig      = bus_wr & (|new_pulse);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pset_d  = pset_q;
        level_d = bus_wr ? (bus_wdata & LM) : level_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = PULSE;
                    cnt_d   = PW5;
                    pset_d  = new_pulse;
                end
            end
            PULSE: begin
                // A retrigger extends every active pulse bit so they all end together
                if (trig) begin
                    cnt_d  = PW5;
                    pset_d = pset_q | new_pulse;
                end else if (cnt_q <= 5'd1) begin
                    state_d = IDLE;
                    pset_d  = 8'h00;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
                pset_d  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            pset_q  <= 8'h00;
            level_q <= InitValue & LM;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pset_q  <= pset_d;
            level_q <= level_d;
            ack_q   <= bus_wr | rd_acc;
        end
    end

    assign control_bus = level_q | pset_q;
    assign bus_ack     = ack_q;

`ifdef CTRLREG_READBACK_EN
    logic [7:0] rdata_q;

    // A read coinciding with a write is dropped; the write's ack covers both
    assign rd_acc = bus_rd & ~bus_wr;

    always_ff @(posedge clock) begin
        if (reset) rdata_q <= 8'h00;
        else       rdata_q <= rd_acc ? control_bus : 8'h00;
    end

    assign bus_rdata = rdata_q;
`else
    logic unused_rd;

    assign unused_rd = bus_rd;
    assign rd_acc    = 1'b0;
    assign bus_rdata = 8'h00;
`endif

    assign control_0 = control_bus[0];
    assign control_1 = control_bus[1];
    assign control_2 = control_bus[2];
    assign control_3 = control_bus[3];
    assign control_4 = control_bus[4];
    assign control_5 = control_bus[5];
    assign control_6 = control_bus[6];
    assign control_7 = control_bus[7];
endmodule

// File: tb/tb_control_reg_driver.sv
// Bench for control_reg_driver: three parameterisations share one bus, checked against
// a pulse-age reference model plus directed spot checks.
module tb_control_reg_driver;
    localparam int         ND = 3;
    localparam int         P_NO [ND] = '{8, 8, 4};
    localparam logic [7:0] P_PM [ND] = '{8'h0F, 8'h00, 8'h01};
    localparam int         P_PW [ND] = '{3, 1, 2};
    localparam logic [7:0] P_IV [ND] = '{8'hA5, 8'h00, 8'hFF};
`ifdef CTRLREG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, wr, rd;
    logic [7:0] wd;
    logic [ND-1:0][7:0] cb, rdat, cbits;
    logic [ND-1:0]      ack;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        control_reg_driver #(
            .NumOutputs(P_NO[g]), .PulseMask(P_PM[g]),
            .PulseWidth(P_PW[g]), .InitValue(P_IV[g])
        ) u_dut (
            .clock(clk), .reset(rst), .bus_wr(wr), .bus_rd(rd), .bus_wdata(wd),
            .bus_rdata(rdat[g]), .bus_ack(ack[g]), .control_bus(cb[g]),
            .control_0(cbits[g][0]), .control_1(cbits[g][1]),
            .control_2(cbits[g][2]), .control_3(cbits[g][3]),
            .control_4(cbits[g][4]), .control_5(cbits[g][5]),
            .control_6(cbits[g][6]), .control_7(cbits[g][7])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: level bits hold the last write; pulse bits are high while the
    // number of clocks since the latest pulse-triggering write is below PulseWidth.
    logic [7:0] m_level [ND];
    logic [7:0] m_pset  [ND];
    int         m_age   [ND];
    logic       m_ack   [ND];
    logic [7:0] m_rdata [ND];

    function automatic logic [7:0] am(input int d);
        return 8'((9'd1 << P_NO[d]) - 9'd1);
    endfunction

    function automatic logic [7:0] exp_cb(input int d);
        return m_level[d] | ((m_age[d] < P_PW[d]) ? m_pset[d] : 8'h00);
    endfunction

    task automatic model_step(input int d);
        logic [7:0] pm, lm, cur, np;
        logic       rd_ok;
        pm = P_PM[d] & am(d);
        lm = ~P_PM[d] & am(d);
        if (rst) begin
            m_level[d] = P_IV[d] & lm;
            m_pset[d]  = 8'h00;
            m_age[d]   = 100;
            m_ack[d]   = 1'b0;
            m_rdata[d] = 8'h00;
        end else begin
            cur        = exp_cb(d);
            rd_ok      = RB && rd && !wr;
            m_ack[d]   = wr || rd_ok;
            m_rdata[d] = rd_ok ? (cur & am(d)) : 8'h00;
            np         = wd & pm;
            if (wr) m_level[d] = wd & lm;
            if (wr && np != 8'h00) begin
                m_pset[d] = ((m_age[d] < P_PW[d]) ? m_pset[d] : 8'h00) | np;
                m_age[d]  = 0;
            end else if (m_age[d] < 100) begin
                m_age[d]++;
            end
        end
    endtask

    task automatic cycle(input logic w, input logic r, input logic [7:0] d, input logic rs);
        wr = w; rd = r; wd = d; rst = rs;
        @(posedge clk);
        for (int i = 0; i < ND; i++) model_step(i);
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("cbus%0d", i), cb[i], exp_cb(i));
            chk($sformatf("bits%0d", i), cbits[i], exp_cb(i));
            chk($sformatf("ack%0d", i), {7'd0, ack[i]}, {7'd0, m_ack[i]});
            chk($sformatf("rdata%0d", i), rdat[i], m_rdata[i]);
        end
    endtask

    int hc;

    initial begin
        wr = 0; rd = 0; wd = 0; rst = 1;
        cycle(0, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 1);
        chk("rst_init", cb[0], 8'hA0);
        chk("rst_ack", {7'd0, ack[0]}, 8'h00);
        cycle(0, 0, 8'h00, 0);

        // level write then readback
        cycle(1, 0, 8'h3C, 0);
        chk("lvl_wr", cb[1], 8'h3C);
        chk("lvl_ack", {7'd0, ack[1]}, 8'h01);
        cycle(0, 1, 8'h00, 0);
        chk("lvl_rd", rdat[1], RB ? 8'h3C : 8'h00);
        chk("lvl_rd_ack", {7'd0, ack[1]}, {7'd0, RB});
        repeat (4) cycle(0, 0, 8'h00, 0);

        // single pulse, width 3
        cycle(1, 0, 8'h01, 0);
        hc = int'(cb[0][0]);
        repeat (5) begin cycle(0, 0, 8'h00, 0); hc += int'(cb[0][0]); end
        chk("pulse_len", 8'(hc), 8'd3);

        // retrigger two clocks into the pulse
        cycle(1, 0, 8'h01, 0);
        hc = int'(cb[0][0]);
        cycle(0, 0, 8'h00, 0); hc += int'(cb[0][0]);
        cycle(1, 0, 8'h01, 0); hc += int'(cb[0][0]);
        repeat (6) begin cycle(0, 0, 8'h00, 0); hc += int'(cb[0][0]); end
        chk("retrig_len", 8'(hc), 8'd5);

        // simultaneous rd+wr on the 4-output instance
        cycle(1, 1, 8'h55, 0);
        chk("rdwr_cbus", cb[2], 8'h05);
        chk("rdwr_ack", {7'd0, ack[2]}, 8'h01);
        chk("rdwr_rdata", rdat[2], 8'h00);
        cycle(0, 0, 8'h00, 0);
        chk("rdwr_one_ack", {7'd0, ack[2]}, 8'h00);
        repeat (3) cycle(0, 0, 8'h00, 0);

        // mid-pulse reset, then reset beating an access
        cycle(1, 0, 8'h01, 0);
        chk("pre_rst_pulse", {7'd0, cb[2][0]}, 8'h01);
        cycle(0, 0, 8'h00, 1);
        chk("mid_rst", {7'd0, cb[2][0]}, 8'h00);
        cycle(1, 1, 8'hFF, 1);
        chk("rst_prio_ack", {7'd0, ack[0]}, 8'h00);
        chk("rst_prio_cbus", cb[0], 8'hA0);
        cycle(0, 0, 8'h00, 0);

        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
                  8'($urandom), ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/control_reg_driver.md
CONTROL_REG_DRIVER -- requirements
Module: control_reg_driver

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
REQ-002 Parameter NumOutputs SHALL default to 8 and set the number of active control bits, range 1..8.
REQ-003 Parameter PulseMask [7:0] SHALL default to 8'h00; bit=1 selects pulse mode for that bit, bit=0 selects level mode.
REQ-004 Parameter PulseWidth SHALL default to 1 and set the pulse length in clocks, range 1..16.
REQ-005 Parameter InitValue [7:0] SHALL default to 8'h00 and set the reset value of the level-mode bits.
REQ-006 Port clock SHALL be an input, 1 bit wide: the rising-edge clock.
REQ-007 Port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-008 Port bus_wr SHALL be an input, 1 bit wide: CPU write strobe, one clock per access.
REQ-009 Port bus_rd SHALL be an input, 1 bit wide: CPU read strobe, one clock per access.
REQ-010 Port bus_wdata SHALL be an input, 8 bits wide: CPU write data.
REQ-011 Port bus_rdata SHALL be an output, 8 bits wide: CPU read data, registered.
REQ-012 Port bus_ack SHALL be an output, 1 bit wide: one-clock acknowledge for each accepted access.
REQ-013 Port control_bus SHALL be an output, 8 bits wide: the driven control nets.
REQ-014 Ports control_0..control_7 SHALL be outputs, 1 bit wide each, equal to control_bus[0]..control_bus[7].

Function
REQ-015 Let active mask AM = (1<<NumOutputs)-1; bits outside AM SHALL read 0, ignore writes and drive 0.
REQ-016 A level-mode bit SHALL take bus_wdata[i] on the clock edge after bus_wr is sampled high (latency 1).
REQ-017 For a pulse-mode bit, writing 1 SHALL assert the output from the clock after bus_wr for exactly PulseWidth clocks, after which the output returns to 0.
REQ-018 For a pulse-mode bit, writing 0 SHALL have no effect, including on a pulse already in progress.
REQ-019 The pulse FSM SHALL have two states. IDLE moves to PULSE on a write with any pulse-mode bit set. PULSE moves to IDLE when the down-counter reaches 1 and no retrigger occurs.
REQ-020 A write that sets any pulse-mode bit while in PULSE SHALL reload the counter to PulseWidth. It SHALL OR the new bits into the active pulse set, and all active pulse bits SHALL end together.
REQ-021 The pulse counter SHALL be 5 bits wide, SHALL load PulseWidth, SHALL decrement once per clock in PULSE, and SHALL never wrap below 1.
REQ-022 bus_ack SHALL be high for exactly one clock, the clock after an accepted bus_wr or bus_rd. Back-to-back accesses SHALL produce back-to-back acks.
REQ-023 If bus_wr and bus_rd are high in the same clock, the write SHALL be performed, the read SHALL be dropped, and a single ack SHALL be issued.
REQ-024 A read SHALL return control_bus & AM, as sampled on the clock bus_rd is high, on bus_rdata during the ack clock. Pulse bits SHALL read as currently driven.
REQ-025 bus_rdata SHALL be 8'h00 whenever bus_ack is low.

Reset
REQ-026 On reset, control_bus SHALL be set to InitValue & ~PulseMask & AM.
REQ-027 On reset, the FSM SHALL go to IDLE, the counter to 0, the active pulse set to 0, bus_ack to 0 and bus_rdata to 8'h00.
REQ-028 Reset during PULSE SHALL terminate the pulse on the next edge.
REQ-029 Reset SHALL take priority over a simultaneous bus_wr or bus_rd, and that access SHALL be neither performed nor acked.

Configuration
REQ-030 With CTRLREG_READBACK_EN defined, REQ-024 SHALL apply.
REQ-031 Without CTRLREG_READBACK_EN, bus_rd SHALL be ignored, reads SHALL not be acked, bus_rdata SHALL be tied to 8'h00, and only writes SHALL be acked.

Verification
REQ-032 Reset with InitValue=8'hA5, PulseMask=8'h0F -> control_bus=8'hA0, bus_ack=0.
REQ-033 Level write: PulseMask=0; write 8'h3C -> control_bus=8'h3C one clock later, ack that clock; read -> bus_rdata=8'h3C (readback build).
REQ-034 Pulse: PulseMask=8'h01, PulseWidth=3; write 8'h01 -> control_0 high exactly 3 clocks, then 0; FSM returns to IDLE.
REQ-035 Retrigger: the same configuration, with a second write 8'h01 two clocks into the pulse -> control_0 stays high for 5 clocks total.
REQ-036 Simultaneous rd+wr of 8'h55 with NumOutputs=4 -> control_bus=8'h05, one ack, read dropped; a mid-pulse reset clears control_0 on the next edge.
